// File: rtl/mc_controller.sv
// ---------------------------------------------------------------------------
// mc_controller
// Multicycle control FSM for the single-memory MIPS core. It steps each
// instruction through fetch, decode, execute, memory and writeback. It drives
// every mux select and write enable of the shared ALU / regfile / IR / memory
// datapath, and stalls on the memory ready handshake.
//
// Ports
//   iClk        clock, rising edge
//   iResetN     asynchronous active-low reset
//   iOp         instruction register [31:26]
//   iFunct      instruction register [5:0]
//   iZero       ALU zero flag (used in BRANCH)
//   iMemReady   memory completes the current access this cycle
//   oPCEn       PC load enable (PCWrite | Branch & iZero)
//   oIorD       memory address select: 0 = PC, 1 = ALUOut
//   oMemRead    memory read request
//   oMemWrite   memory write request
//   oIRWrite    instruction register load
//   oMemToReg   regfile write data: 0 = ALUOut, 1 = MDR
//   oRegDst     regfile write address: 0 = rt, 1 = rd
//   oRegWrite   regfile write enable
//   oALUSrcA    0 = PC, 1 = register A
//   oALUSrcB    00 = B, 01 = 4, 10 = imm, 11 = imm << 2
//   oALUControl 010 add, 110 sub, 000 and, 001 or, 111 slt
//   oPCSrc      00 = ALU result, 01 = ALUOut, 10 = jump target
//   oState      current state encoding (debug)
//   oIllegal    sticky flag: unsupported opcode/funct decoded
// ---------------------------------------------------------------------------
module mc_controller (
  input  logic       iClk,
  input  logic       iResetN,
  input  logic [5:0] iOp,
  input  logic [5:0] iFunct,
  input  logic       iZero,
  input  logic       iMemReady,
  output logic       oPCEn,
  output logic       oIorD,
  output logic       oMemRead,
  output logic       oMemWrite,
  output logic       oIRWrite,
  output logic       oMemToReg,
  output logic       oRegDst,
  output logic       oRegWrite,
  output logic       oALUSrcA,
  output logic [1:0] oALUSrcB,
  output logic [2:0] oALUControl,
  output logic [1:0] oPCSrc,
  output logic [3:0] oState,
  output logic       oIllegal
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state;
  logic   illegal;
  logic   funct_ok;
  logic [2:0] funct_alu;

  // Moore control values decoded from the state register, before reset gating
  logic       pc_write;
  logic       branch;
  logic       ior_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] pc_src;

  // R-type funct decode: which functs are supported and the ALU operation each selects
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (iFunct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  // State sequencing and the sticky illegal flag. Only reset clears the flag.
  // Unused encodings 12-15 fall through to FETCH.
  always_ff @(posedge iClk or negedge iResetN) begin
    if (!iResetN) begin
      state   <= FETCH;
      illegal <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (iMemReady) state <= DECODE;
        end
        DECODE: begin
          case (iOp)
            OP_LW, OP_SW: state <= MEMADR;
            OP_RTYPE: begin
              if (funct_ok) begin
                state <= EXEC;
              end else begin
                state   <= FETCH;
                illegal <= 1'b1;
              end
            end
            OP_BEQ:  state <= BRANCH;
            OP_ADDI: state <= ADDIEX;
            OP_J:    state <= JUMP;
            default: begin
              state   <= FETCH;
              illegal <= 1'b1;
            end
          endcase
        end
        MEMADR: state <= (iOp == OP_SW) ? MEMWR : MEMRD;
        MEMRD: begin
          if (iMemReady) state <= MEMWB;
        end
        MEMWB: state <= FETCH;
        MEMWR: begin
          if (iMemReady) state <= FETCH;
        end
        EXEC:    state <= ALUWB;
        ALUWB:   state <= FETCH;
        BRANCH:  state <= FETCH;
        ADDIEX:  state <= ADDIWB;
        ADDIWB:  state <= FETCH;
        JUMP:    state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  // Per-state control decode. The FETCH PC write and IR load wait for the
  // memory handshake, so a fetch stall leaves PC and IR untouched.
  always_comb begin
    pc_write    = 1'b0;
    branch      = 1'b0;
    ior_d       = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    mem_to_reg  = 1'b0;
    reg_dst     = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    pc_src      = 2'b00;
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = iMemReady;
        pc_write  = iMemReady;
      end
      DECODE: begin
        // Branch target is precomputed into ALUOut while the opcode is decoded
        alu_src_b = 2'b11;
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        ior_d    = 1'b1;
        mem_read = 1'b1;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      MEMWR: begin
        ior_d     = 1'b1;
        mem_write = 1'b1;
      end
      EXEC: begin
        alu_src_a   = 1'b1;
        alu_control = funct_alu;
      end
      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        branch      = 1'b1;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDIWB: begin
        reg_write = 1'b1;
      end
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // While reset is held, the requests and write enables are forced off.
  // The select outputs already show FETCH values because the state is FETCH.
  assign oPCEn       = iResetN & (pc_write | (branch & iZero));
  assign oIRWrite    = iResetN & ir_write;
  assign oMemRead    = iResetN & mem_read;
  assign oMemWrite   = iResetN & mem_write;
  assign oRegWrite   = iResetN & reg_write;
  assign oIorD       = ior_d;
  assign oMemToReg   = mem_to_reg;
  assign oRegDst     = reg_dst;
  assign oALUSrcA    = alu_src_a;
  assign oALUSrcB    = alu_src_b;
  assign oALUControl = alu_control;
  assign oPCSrc      = pc_src;
  assign oState      = state;
  assign oIllegal    = illegal;

endmodule

// File: tb/tb_mc_controller.sv
// ---------------------------------------------------------------------------
// tb_mc_controller
// Directed bench for mc_controller. It walks the controller through each
// instruction class, with and without memory stalls. Each cycle it compares
// the state and the full control word against hand-written expected values.
// Outputs are sampled 1 ns after the falling edge.
// ---------------------------------------------------------------------------
module tb_mc_controller;

  logic       iClk;
  logic       iResetN;
  logic [5:0] iOp;
  logic [5:0] iFunct;
  logic       iZero;
  logic       iMemReady;
  logic       oPCEn;
  logic       oIorD;
  logic       oMemRead;
  logic       oMemWrite;
  logic       oIRWrite;
  logic       oMemToReg;
  logic       oRegDst;
  logic       oRegWrite;
  logic       oALUSrcA;
  logic [1:0] oALUSrcB;
  logic [2:0] oALUControl;
  logic [1:0] oPCSrc;
  logic [3:0] oState;
  logic       oIllegal;

  int vectorCount = 0;
  int missCount   = 0;

  logic [15:0] ctl;

  mc_controller dut (
    .iClk        (iClk),
    .iResetN     (iResetN),
    .iOp         (iOp),
    .iFunct      (iFunct),
    .iZero       (iZero),
    .iMemReady   (iMemReady),
    .oPCEn       (oPCEn),
    .oIorD       (oIorD),
    .oMemRead    (oMemRead),
    .oMemWrite   (oMemWrite),
    .oIRWrite    (oIRWrite),
    .oMemToReg   (oMemToReg),
    .oRegDst     (oRegDst),
    .oRegWrite   (oRegWrite),
    .oALUSrcA    (oALUSrcA),
    .oALUSrcB    (oALUSrcB),
    .oALUControl (oALUControl),
    .oPCSrc      (oPCSrc),
    .oState      (oState),
    .oIllegal    (oIllegal)
  );

  // Free-running 10 ns clock
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // All control outputs packed into one word so each cycle is a single compare
  assign ctl = {oPCEn, oIorD, oMemRead, oMemWrite, oIRWrite, oMemToReg, oRegDst,
                oRegWrite, oALUSrcA, oALUSrcB, oALUControl, oPCSrc};

  // Builds an expected control word in the same field order as ctl
  function automatic logic [15:0] cw(input logic pcEn, input logic iorD,
                                     input logic memRead, input logic memWrite,
                                     input logic irWrite, input logic memToReg,
                                     input logic regDst, input logic regWrite,
                                     input logic srcA, input logic [1:0] srcB,
                                     input logic [2:0] alu, input logic [1:0] pcSrc);
    return {pcEn, iorD, memRead, memWrite, irWrite, memToReg, regDst, regWrite,
            srcA, srcB, alu, pcSrc};
  endfunction

  // Single comparison point: counts the vector and reports any miscompare
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] funct,
                               input logic ready, input logic zero);
    iOp       = op;
    iFunct    = funct;
    iMemReady = ready;
    iZero     = zero;
    #1;
  endtask

  task automatic checkCycle(input string tag, input logic [3:0] expState,
                            input logic [15:0] expCtl);
    checkOutput({tag, ".state"}, {12'd0, oState}, {12'd0, expState});
    checkOutput({tag, ".ctl"}, ctl, expCtl);
  endtask

  task automatic advance();
    @(negedge iClk);
    #1;
  endtask

  // Expected words for the input-independent states
  localparam logic [15:0] W_DECODE = 16'b0_0_0_0_0_0_0_0_0_11_010_00;
  localparam logic [15:0] W_FETCHR = 16'b1_0_1_0_1_0_0_0_0_01_010_00;
  localparam logic [15:0] W_FETCHS = 16'b0_0_1_0_0_0_0_0_0_01_010_00;
  localparam logic [15:0] W_RESET  = 16'b0_0_0_0_0_0_0_0_0_01_010_00;

  initial begin
    iResetN   = 1'b0;
    iOp       = 6'd0;
    iFunct    = 6'd0;
    iZero     = 1'b0;
    iMemReady = 1'b1;

    // Reset held: FETCH selects visible, enables forced off
    #13;
    applyStimulus(6'b000000, 6'b100000, 1'b1, 1'b0);
    checkCycle("reset", 4'd0, W_RESET);
    checkOutput("reset.illegal", {15'd0, oIllegal}, 16'd0);
    advance();
    iResetN = 1'b1;

    // R-type add: 0,1,6,7,0
    applyStimulus(6'b000000, 6'b100000, 1'b1, 1'b0);
    checkCycle("add.fetch", 4'd0, W_FETCHR);
    advance();
    checkCycle("add.decode", 4'd1, W_DECODE);
    advance();
    checkCycle("add.exec", 4'd6, cw(0,0,0,0,0,0,0,0,1,2'b00,3'b010,2'b00));
    advance();
    checkCycle("add.aluwb", 4'd7, cw(0,0,0,0,0,0,1,1,0,2'b00,3'b010,2'b00));
    advance();

    // lw with two MEMRD stalls: 0,1,2,3,3,3,4,0
    applyStimulus(6'b100011, 6'b000000, 1'b1, 1'b0);
    checkCycle("lw.fetch", 4'd0, W_FETCHR);
    advance();
    checkCycle("lw.decode", 4'd1, W_DECODE);
    advance();
    checkCycle("lw.memadr", 4'd2, cw(0,0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00));
    advance();
    applyStimulus(6'b100011, 6'b000000, 1'b0, 1'b0);
    checkCycle("lw.memrd0", 4'd3, cw(0,1,1,0,0,0,0,0,0,2'b00,3'b010,2'b00));
    advance();
    checkCycle("lw.memrd1", 4'd3, cw(0,1,1,0,0,0,0,0,0,2'b00,3'b010,2'b00));
    advance();
    applyStimulus(6'b100011, 6'b000000, 1'b1, 1'b0);
    checkCycle("lw.memrd2", 4'd3, cw(0,1,1,0,0,0,0,0,0,2'b00,3'b010,2'b00));
    advance();
    checkCycle("lw.memwb", 4'd4, cw(0,0,0,0,0,1,0,1,0,2'b00,3'b010,2'b00));
    advance();

    // beq taken, preceded by one fetch stall
    applyStimulus(6'b000100, 6'b000000, 1'b0, 1'b1);
    checkCycle("beq1.fetchstall", 4'd0, W_FETCHS);
    advance();
    applyStimulus(6'b000100, 6'b000000, 1'b1, 1'b1);
    checkCycle("beq1.fetch", 4'd0, W_FETCHR);
    advance();
    checkCycle("beq1.decode", 4'd1, W_DECODE);
    advance();
    checkCycle("beq1.branch", 4'd8, cw(1,0,0,0,0,0,0,0,1,2'b00,3'b110,2'b01));
    advance();

    // beq not taken
    applyStimulus(6'b000100, 6'b000000, 1'b1, 1'b0);
    checkCycle("beq0.fetch", 4'd0, W_FETCHR);
    advance();
    checkCycle("beq0.decode", 4'd1, W_DECODE);
    advance();
    checkCycle("beq0.branch", 4'd8, cw(0,0,0,0,0,0,0,0,1,2'b00,3'b110,2'b01));
    advance();

    // sw with one MEMWR stall: 0,1,2,5,5,0
    applyStimulus(6'b101011, 6'b000000, 1'b1, 1'b0);
    checkCycle("sw.fetch", 4'd0, W_FETCHR);
    advance();
    checkCycle("sw.decode", 4'd1, W_DECODE);
    advance();
    checkCycle("sw.memadr", 4'd2, cw(0,0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00));
    advance();
    applyStimulus(6'b101011, 6'b000000, 1'b0, 1'b0);
    checkCycle("sw.memwr0", 4'd5, cw(0,1,0,1,0,0,0,0,0,2'b00,3'b010,2'b00));
    advance();
    applyStimulus(6'b101011, 6'b000000, 1'b1, 1'b0);
    checkCycle("sw.memwr1", 4'd5, cw(0,1,0,1,0,0,0,0,0,2'b00,3'b010,2'b00));
    advance();

    // j: 0,1,11
    applyStimulus(6'b000010, 6'b000000, 1'b1, 1'b0);
    checkCycle("j.fetch", 4'd0, W_FETCHR);
    advance();
    checkCycle("j.decode", 4'd1, W_DECODE);
    advance();
    checkCycle("j.jump", 4'd11, cw(1,0,0,0,0,0,0,0,0,2'b00,3'b010,2'b10));
    advance();

    // R-type slt selects 111 in EXEC
    applyStimulus(6'b000000, 6'b101010, 1'b1, 1'b0);
    checkCycle("slt.fetch", 4'd0, W_FETCHR);
    advance();
    advance();
    checkCycle("slt.exec", 4'd6, cw(0,0,0,0,0,0,0,0,1,2'b00,3'b111,2'b00));
    advance();
    advance();

    // Illegal opcode: back to FETCH after DECODE, flag sticks
    applyStimulus(6'b111111, 6'b000000, 1'b1, 1'b0);
    checkOutput("ill.before", {15'd0, oIllegal}, 16'd0);
    checkCycle("ill.fetch", 4'd0, W_FETCHR);
    advance();
    checkCycle("ill.decode", 4'd1, W_DECODE);
    advance();
    checkCycle("ill.refetch", 4'd0, W_FETCHR);
    checkOutput("ill.flag", {15'd0, oIllegal}, 16'd1);

    // addi after the illegal op: 0,1,9,10,0
    applyStimulus(6'b001000, 6'b000000, 1'b1, 1'b0);
    advance();
    checkCycle("addi.decode", 4'd1, W_DECODE);
    advance();
    checkCycle("addi.ex", 4'd9, cw(0,0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00));
    advance();
    checkCycle("addi.wb", 4'd10, cw(0,0,0,0,0,0,0,1,0,2'b00,3'b010,2'b00));
    advance();
    checkCycle("addi.done", 4'd0, W_FETCHR);
    checkOutput("addi.illegal", {15'd0, oIllegal}, 16'd1);

    // Reset mid-EXEC: immediate return to FETCH, enables off, flag cleared
    applyStimulus(6'b000000, 6'b100000, 1'b1, 1'b0);
    advance();
    advance();
    checkCycle("rst.exec", 4'd6, cw(0,0,0,0,0,0,0,0,1,2'b00,3'b010,2'b00));
    iResetN = 1'b0;
    #1;
    checkCycle("rst.async", 4'd0, W_RESET);
    checkOutput("rst.illegal", {15'd0, oIllegal}, 16'd0);
    advance();
    checkCycle("rst.held", 4'd0, W_RESET);
    iResetN = 1'b1;
    #1;
    checkCycle("rst.release", 4'd0, W_FETCHR);
    advance();
    checkCycle("rst.decode", 4'd1, W_DECODE);
    checkOutput("rst.illegal2", {15'd0, oIllegal}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
